// File: rtl/risc_v_pkg.sv
// Shared definitions for the write-back commit tracker: register file
// geometry and the default trace entry layout.
package risc_v_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int DEF_XLEN   = 32;
    localparam int DEF_SEQW   = 16;

    // One retired register write as seen on the trace drain port.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DEF_XLEN-1:0]   data;
        logic [DEF_SEQW-1:0]   seq;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace entries. Push side is a plain enable plus a
// full flag; pop side is valid/ready. The head is read straight from the
// storage array at rdPtr, so it only changes when an entry is popped.
// There is no fall-through: a push into an empty FIFO becomes visible on
// the following cycle.
//
// Handshake: an entry leaves the FIFO on a clock edge where valid and
// ready are both high; valid never depends on ready, and the head data is
// held stable while valid is high and ready is low.
module trace_fifo
    import risc_v_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = trace_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 pushData,
    output logic                   full,
    output logic                   valid,
    input  logic                   ready,
    output entry_t                 headData,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   cnt;
    logic          pop;
    logic          pushOk;

    assign valid    = (cnt != '0);
    assign full     = (cnt == FULL_CNT);
    assign pop      = valid && ready;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign pushOk   = push && (!full || pop);
    assign headData = mem[rdPtr];
    assign count    = cnt;

    // Storage write; contents need no reset because cnt gates visibility.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({pushOk, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/wb_commit_tracker.sv
// Passive observer of the CPU write-back stream. Mirrors the architectural
// register file, numbers every retired register write, and queues those
// writes for a trace drain port. It never stalls the pipeline: when the
// queue is full a commit is dropped, its sequence number is still consumed,
// and a sticky overflow flag records the loss.
module wb_commit_tracker
    import risc_v_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = DEF_XLEN,
    parameter int SEQW  = DEF_SEQW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   RegWriteW,
    input  logic [REG_ADDR_W-1:0]  RdW,
    input  logic [XLEN-1:0]        ResultW,
    output logic                   trace_valid,
    input  logic                   trace_ready,
    output logic [REG_ADDR_W-1:0]  trace_rd,
    output logic [XLEN-1:0]        trace_data,
    output logic [SEQW-1:0]        trace_seq,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    input  logic                   ovf_clr,
    input  logic [REG_ADDR_W-1:0]  dbg_addr,
    output logic [XLEN-1:0]        dbg_data
);

    // Entry layout sized to this instance's data and sequence widths.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
        logic [SEQW-1:0]       seq;
    } entry_t;

    logic [XLEN-1:0] shadow [NUM_REGS];
    logic [SEQW-1:0] seq;
    logic            commit;
    logic            fifoFull;
    logic            pop;
    logic            push;
    entry_t          pushEntry;
    entry_t          headEntry;

    // Writes to x0 are architecturally invisible, so they are not commits.
    assign commit = RegWriteW && (RdW != '0);
    assign pop    = trace_valid && trace_ready;
    assign push   = commit && (!fifoFull || pop);

    assign pushEntry = '{rd: RdW, data: ResultW, seq: seq};

    trace_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pushData (pushEntry),
        .full     (fifoFull),
        .valid    (trace_valid),
        .ready    (trace_ready),
        .headData (headEntry),
        .count    (fifo_count)
    );

    assign trace_rd   = headEntry.rd;
    assign trace_data = headEntry.data;
    assign trace_seq  = headEntry.seq;

    // Shadow register file; entry 0 is never written and stays zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
            end
        end else if (commit) begin
            shadow[RdW] <= ResultW;
        end
    end

    // Debug read port: no bypass, a new value shows up the cycle after its commit.
    always_comb begin
        dbg_data = '0;
        if (dbg_addr != '0) begin
            dbg_data = shadow[dbg_addr];
        end
    end

    // Sequence counter advances on every commit, dropped or not, so gaps expose loss.
    always_ff @(posedge clk) begin
        if (!reset) begin
            seq <= '0;
        end else if (commit) begin
            seq <= seq + 1'b1;
        end
    end

    // Sticky overflow: a fresh loss takes priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (commit && fifoFull && !pop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_commit_tracker.sv
// Directed bench for wb_commit_tracker: reset state, single commit, x0
// writes, overflow and loss gaps, full-with-pop, overflow clear priority,
// sequence wrap and mid-stream reset.
module tb_wb_commit_tracker;

    logic        clk;
    logic        reset;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        trace_valid;
    logic        trace_ready;
    logic [4:0]  trace_rd;
    logic [31:0] trace_data;
    logic [15:0] trace_seq;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        ovf_clr;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checkCount = 0;
    int errCount   = 0;

    // Expected drain entries packed as {rd, data, seq}.
    logic [52:0] exp_q[$];

    wb_commit_tracker #(.DEPTH(8), .XLEN(32), .SEQW(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .RegWriteW   (RegWriteW),
        .RdW         (RdW),
        .ResultW     (ResultW),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_rd    (trace_rd),
        .trace_data  (trace_data),
        .trace_seq   (trace_seq),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic commitReg(input logic [4:0] rd, input logic [31:0] data);
        RegWriteW = 1'b1;
        RdW       = rd;
        ResultW   = data;
        tick();
        RegWriteW = 1'b0;
    endtask

    task automatic checkHead(input string tag, input logic [52:0] e);
        checkVal({tag, "_valid"}, 64'(trace_valid), 64'd1);
        checkVal({tag, "_rd"},    64'(trace_rd),    64'(e[52:48]));
        checkVal({tag, "_data"},  64'(trace_data),  64'(e[47:16]));
        checkVal({tag, "_seq"},   64'(trace_seq),   64'(e[15:0]));
    endtask

    task automatic drainQueue(input string tag);
        logic [52:0] e;
        trace_ready = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkHead(tag, e);
            tick();
        end
        trace_ready = 1'b0;
        checkVal({tag, "_empty"}, 64'(fifo_count), 64'd0);
    endtask

    initial begin
        reset       = 1'b0;
        RegWriteW   = 1'b0;
        RdW         = '0;
        ResultW     = '0;
        trace_ready = 1'b0;
        ovf_clr     = 1'b0;
        dbg_addr    = '0;

        // 1. Reset held two cycles, then idle
        tick();
        tick();
        reset = 1'b1;
        tick();
        checkVal("rst_valid", 64'(trace_valid), 64'd0);
        checkVal("rst_count", 64'(fifo_count), 64'd0);
        checkVal("rst_ovf",   64'(overflow),   64'd0);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            checkVal($sformatf("rst_dbg_x%0d", a), 64'(dbg_data), 64'd0);
        end

        // 2. Single commit x5 = DEADBEEF, drain held off
        @(posedge clk);
        #1;
        RegWriteW = 1'b1;
        RdW       = 5'd5;
        ResultW   = 32'hDEAD_BEEF;
        dbg_addr  = 5'd5;
        #1;
        checkVal("c1_no_bypass", 64'(dbg_data), 64'd0);
        checkVal("c1_no_fallthru", 64'(trace_valid), 64'd0);
        tick();
        RegWriteW = 1'b0;
        checkHead("c1", {5'd5, 32'hDEAD_BEEF, 16'd0});
        checkVal("c1_count", 64'(fifo_count), 64'd1);
        checkVal("c1_dbg",   64'(dbg_data),   64'hDEAD_BEEF);
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
        checkVal("c1_drained", 64'(trace_valid), 64'd0);

        // Empty with ready high: nothing happens
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
        checkVal("empty_rdy_count", 64'(fifo_count), 64'd0);

        // 3. Write to x0 is not a commit
        commitReg(5'd0, 32'h1234);
        dbg_addr = 5'd0;
        #1;
        checkVal("x0_count", 64'(fifo_count), 64'd0);
        checkVal("x0_valid", 64'(trace_valid), 64'd0);
        checkVal("x0_dbg",   64'(dbg_data),    64'd0);
        // seq must still be 1 after the x0 write
        commitReg(5'd7, 32'h77);
        exp_q.push_back({5'd7, 32'h77, 16'd1});
        drainQueue("x0_seq");

        // 4. Nine commits into an 8-deep FIFO with drain held off
        doReset();
        for (int i = 1; i <= 9; i++) begin
            commitReg(5'(i), 32'(i));
        end
        checkVal("ovf_count", 64'(fifo_count), 64'd8);
        checkVal("ovf_flag",  64'(overflow),   64'd1);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({5'(i + 1), 32'(i + 1), 16'(i)});
        end
        drainQueue("ovf_drain");
        checkVal("ovf_sticky", 64'(overflow), 64'd1);
        commitReg(5'd11, 32'h11);
        checkHead("after_loss", {5'd11, 32'h11, 16'd9});
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checkVal("ovf_cleared", 64'(overflow), 64'd0);
        exp_q.push_back({5'd11, 32'h11, 16'd9});
        drainQueue("after_loss_drain");

        // 5. Fill (seq 10..17), lost commit with clear (seq 18), then full + pop
        for (int i = 1; i <= 8; i++) begin
            commitReg(5'(i), 32'h100 + 32'(i));
        end
        checkVal("fill_count", 64'(fifo_count), 64'd8);
        checkVal("fill_ovf",   64'(overflow),   64'd0);
        ovf_clr = 1'b1;
        commitReg(5'd11, 32'hBAD);
        ovf_clr = 1'b0;
        checkVal("set_wins_ovf", 64'(overflow), 64'd1);
        checkVal("set_wins_count", 64'(fifo_count), 64'd8);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checkVal("clr_ovf", 64'(overflow), 64'd0);
        trace_ready = 1'b1;
        commitReg(5'd10, 32'hA5);
        trace_ready = 1'b0;
        checkVal("fullpop_count", 64'(fifo_count), 64'd8);
        checkVal("fullpop_ovf",   64'(overflow),   64'd0);
        for (int i = 2; i <= 8; i++) begin
            exp_q.push_back({5'(i), 32'h100 + 32'(i), 16'(i + 9)});
        end
        exp_q.push_back({5'd10, 32'hA5, 16'd19});
        drainQueue("fullpop_drain");

        // 6. Sequence wrap, then reset mid-stream
        doReset();
        trace_ready = 1'b1;
        RegWriteW   = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            RdW     = 5'((i % 31) + 1);
            ResultW = 32'(i);
            tick();
        end
        RegWriteW = 1'b0;
        tick();
        trace_ready = 1'b0;
        checkVal("wrap_pre_count", 64'(fifo_count), 64'd0);
        commitReg(5'd3, 32'hAAAA);
        commitReg(5'd4, 32'hBBBB);
        checkVal("wrap_count", 64'(fifo_count), 64'd2);
        checkHead("wrap_ffff", {5'd3, 32'hAAAA, 16'hFFFF});
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
        checkHead("wrap_0000", {5'd4, 32'hBBBB, 16'h0000});
        dbg_addr = 5'd4;
        #1;
        checkVal("wrap_dbg", 64'(dbg_data), 64'hBBBB);

        // Reset with a commit presented in the same cycle
        reset     = 1'b0;
        RegWriteW = 1'b1;
        RdW       = 5'd6;
        ResultW   = 32'h66;
        tick();
        reset     = 1'b1;
        RegWriteW = 1'b0;
        checkVal("mid_rst_count", 64'(fifo_count), 64'd0);
        checkVal("mid_rst_valid", 64'(trace_valid), 64'd0);
        checkVal("mid_rst_dbg4",  64'(dbg_data),    64'd0);
        dbg_addr = 5'd6;
        #1;
        checkVal("mid_rst_dbg6", 64'(dbg_data), 64'd0);
        tick();
        checkVal("post_rst_count", 64'(fifo_count), 64'd0);
        commitReg(5'd9, 32'h99);
        checkHead("post_rst", {5'd9, 32'h99, 16'd0});

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end

endmodule
